// File: rtl/stack_arbiter.sv
// stack_arbiter: round-robin req/ack arbiter granting two requesters access to one LIFO stack.
// Optional STACK_ARB_STATS_EN builds a saturating reject counter on reject_count.
module stack_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH = 3,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  op0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  req1,
    input  logic                  op1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [CW-1:0]         count,
    output logic                  busy,
    output logic                  stk_push,
    output logic                  stk_pop,
    output logic [DATA_WIDTH-1:0] stk_data_in,
    input  logic [DATA_WIDTH-1:0] stk_data_out,
    output logic [7:0]            reject_count
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;
    state_t state_q, state_d;
    logic ack0_q, ack0_d, ack1_q, ack1_d, err_q, err_d, busy_q;
    logic push_q, push_d, pop_q, pop_d, last_q, last_d, id_q, id_d, op_q, op_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d, din_q, din_d, gdata;
    logic [CW-1:0] count_q, count_d;
    logic el0, el1, gnt, gop, reject, take;

    // A requester whose ack is high this cycle is holding a stale req and is ignored.
    assign el0 = req0 && !ack0_q;
    assign el1 = req1 && !ack1_q;
    assign gnt = (el0 && el1) ? !last_q : el1;
    assign gop = gnt ? op1 : op0;
    assign gdata = gnt ? wdata1 : wdata0;
    assign reject = gop ? (count_q == CW'(DEPTH)) : (count_q == '0);
    assign take = (state_q == IDLE) && (el0 || el1);

    always_comb begin
        state_d = state_q;
        ack0_d = 1'b0;
        ack1_d = 1'b0;
        err_d = 1'b0;
        push_d = 1'b0;
        pop_d = 1'b0;
        last_d = last_q;
        id_d = id_q;
        op_d = op_q;
        rdata_d = rdata_q;
        din_d = din_q;
        count_d = count_q;
        case (state_q)
            IDLE: if (take) begin
                last_d = gnt;
                id_d = gnt;
                op_d = gop;
                if (reject) begin
                    ack0_d = !gnt;
                    ack1_d = gnt;
                    err_d = 1'b1;
                end else begin
                    state_d = ISSUE;
                    push_d = gop;
                    pop_d = !gop;
                    din_d = gop ? gdata : din_q;
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
                count_d = op_q ? count_q + CW'(1) : count_q - CW'(1);
            end
            CAPTURE: begin
                state_d = IDLE;
                ack0_d = !id_q;
                ack1_d = id_q;
                rdata_d = op_q ? rdata_q : stk_data_out;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            err_q <= 1'b0;
            busy_q <= 1'b0;
            push_q <= 1'b0;
            pop_q <= 1'b0;
            last_q <= 1'b1;
            id_q <= 1'b0;
            op_q <= 1'b0;
            rdata_q <= '0;
            din_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ack0_q <= ack0_d;
            ack1_q <= ack1_d;
            err_q <= err_d;
            busy_q <= state_d != IDLE;
            push_q <= push_d;
            pop_q <= pop_d;
            last_q <= last_d;
            id_q <= id_d;
            op_q <= op_d;
            rdata_q <= rdata_d;
            din_q <= din_d;
            count_q <= count_d;
        end
    end

    assign ack0 = ack0_q;
    assign ack1 = ack1_q;
    assign err = err_q;
    assign rdata = rdata_q;
    assign count = count_q;
    assign busy = busy_q;
    assign stk_push = push_q;
    assign stk_pop = pop_q;
    assign stk_data_in = din_q;

`ifdef STACK_ARB_STATS_EN
    logic [7:0] rej_q;
    always_ff @(posedge clock) begin
        if (reset) rej_q <= '0;
        else if (take && reject && rej_q != 8'hFF) rej_q <= rej_q + 8'd1;
    end
    assign reject_count = rej_q;
`else
    assign reject_count = '0;
`endif
endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter: directed, table-driven bench for stack_arbiter with a behavioural 3-deep LIFO.
module tb_stack_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic req0 = 1'b0, op0 = 1'b0, req1 = 1'b0, op1 = 1'b0;
    logic [15:0] wdata0 = '0, wdata1 = '0;
    logic ack0, ack1, err, busy, stk_push, stk_pop;
    logic [15:0] rdata, stk_data_in, stk_data_out;
    logic [1:0] count;
    logic [7:0] reject_count;
    int errors = 0, checks = 0;
    int n_push = 0, n_pop = 0, both_hi = 0;

    always #5 clock = ~clock;

    stack_arbiter #(.DATA_WIDTH(16), .DEPTH(3)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .op0(op0), .wdata0(wdata0),
        .req1(req1), .op1(op1), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err(err), .rdata(rdata), .count(count), .busy(busy),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_data_in(stk_data_in),
        .stk_data_out(stk_data_out), .reject_count(reject_count)
    );

    logic [15:0] mem [0:2];
    int sp = 0;
    always @(posedge clock) begin
        if (reset) begin
            sp <= 0;
            stk_data_out <= '0;
        end else if (stk_push && sp < 3) begin
            mem[sp] <= stk_data_in;
            sp <= sp + 1;
        end else if (stk_pop && sp > 0) begin
            stk_data_out <= mem[sp-1];
            sp <= sp - 1;
        end
        n_push <= n_push + int'(stk_push);
        n_pop <= n_pop + int'(stk_pop);
        both_hi <= both_hi + int'(stk_push && stk_pop);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic xact(input bit who, input bit op, input logic [15:0] wd, output int lat);
        @(negedge clock);
        if (who) begin req1 = 1'b1; op1 = op; wdata1 = wd; end
        else begin req0 = 1'b1; op0 = op; wdata0 = wd; end
        lat = 0;
        do begin @(negedge clock); lat++; end while (!(who ? ack1 : ack0) && lat < 20);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    typedef struct {
        bit who;
        bit op;
        logic [15:0] wd;
        bit e_err;
        logic [15:0] e_rdata;
        int e_cnt;
    } vec_t;
    vec_t tbl [8];

    initial begin
        int lat, p0, q0, got, bad;
        logic [3:0] seq;
        tbl[0] = '{1'b0, 1'b1, 16'h1111, 1'b0, 16'h0000, 1};
        tbl[1] = '{1'b0, 1'b1, 16'h2222, 1'b0, 16'h0000, 2};
        tbl[2] = '{1'b0, 1'b1, 16'h3333, 1'b0, 16'h0000, 3};
        tbl[3] = '{1'b0, 1'b1, 16'h4444, 1'b1, 16'h0000, 3};
        tbl[4] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h3333, 2};
        tbl[5] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h2222, 1};
        tbl[6] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h1111, 0};
        tbl[7] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h1111, 0};

        repeat (2) @(negedge clock);
        chk("rst_ack0", ack0, 0);
        chk("rst_ack1", ack1, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {stk_push, stk_pop}, 0);
        chk("rst_data_in", stk_data_in, 0);
        chk("rst_reject_count", reject_count, 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            p0 = n_push;
            q0 = n_pop;
            xact(tbl[i].who, tbl[i].op, tbl[i].wd, lat);
            chk($sformatf("v%0d_latency", i), lat, tbl[i].e_err ? 1 : 3);
            chk($sformatf("v%0d_err", i), err, tbl[i].e_err);
            chk($sformatf("v%0d_rdata", i), rdata, tbl[i].e_rdata);
            chk($sformatf("v%0d_count", i), count, tbl[i].e_cnt);
            chk($sformatf("v%0d_strobes", i), {n_push - p0, n_pop - q0},
                {32'(tbl[i].op && !tbl[i].e_err), 32'(!tbl[i].op && !tbl[i].e_err)});
        end

        // Both requesters held from the same cycle: grants must alternate starting with 0.
        do_reset();
        @(negedge clock);
        req0 = 1'b1; op0 = 1'b1; wdata0 = 16'hA5A5;
        req1 = 1'b1; op1 = 1'b0;
        got = 0;
        seq = '0;
        for (int c = 0; c < 60 && got < 4; c++) begin
            @(negedge clock);
            if (ack1) chk("rr_pop_rdata", {err, rdata}, {1'b0, 16'hA5A5});
            if (ack0 || ack1) begin
                seq = {seq[2:0], ack1};
                got++;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        chk("rr_ack_total", got, 4);
        chk("rr_order", seq, 4'b0101);
        chk("rr_count", count, 0);

        // Requester 0 arrives while requester 1's pop is in flight and must be served next.
        xact(1'b0, 1'b1, 16'h00AA, lat);
        chk("wait_setup_count", count, 1);
        @(negedge clock);
        req1 = 1'b1; op1 = 1'b0;
        @(negedge clock);
        req0 = 1'b1; op0 = 1'b1; wdata0 = 16'h0055;
        lat = 0;
        do begin @(negedge clock); lat++; end while (!ack1 && lat < 20);
        req1 = 1'b0;
        chk("wait_ack1_latency", lat, 2);
        chk("wait_pop_rdata", {err, rdata}, {1'b0, 16'h00AA});
        lat = 0;
        do begin @(negedge clock); lat++; end while (!ack0 && lat < 20);
        req0 = 1'b0;
        chk("wait_ack0_after_ack1", lat, 3);
        chk("wait_push_err", err, 0);
        chk("wait_count", count, 1);
        xact(1'b1, 1'b0, 16'h0000, lat);
        chk("wait_popback_rdata", rdata, 16'h0055);
        chk("wait_final_count", count, 0);

        // Reset during the ISSUE cycle of a push.
        @(negedge clock);
        req0 = 1'b1; op0 = 1'b1; wdata0 = 16'h7777;
        @(negedge clock);
        chk("mid_issue_push", {stk_push, busy}, 2'b11);
        reset = 1'b1;
        req0 = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        chk("mid_rst_strobes", {stk_push, stk_pop}, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_busy", busy, 0);
        got = 0;
        for (int c = 0; c < 6; c++) begin
            got += int'(ack0 || ack1);
            @(negedge clock);
        end
        chk("mid_rst_no_ack", got, 0);

        // Repeated pops on an empty stack exercise the reject counter.
        do_reset();
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            xact(1'b0, 1'b0, 16'h0000, lat);
            bad += int'(lat != 1 || !err);
`ifdef STACK_ARB_STATS_EN
            if (i == 9) chk("stats_after_10", reject_count, 10);
`else
            if (i == 9) chk("stats_after_10", reject_count, 0);
`endif
        end
        chk("stats_all_rejected", bad, 0);
`ifdef STACK_ARB_STATS_EN
        chk("stats_saturated", reject_count, 255);
`else
        chk("stats_tied_zero", reject_count, 0);
`endif
        chk("strobes_exclusive", both_hi, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stack_arbiter.md
Name: stack_arbiter

Overview:
- Shares one LIFO stack instance (push/pop strobes, data_in, data_out) between two requesters using a req/ack handshake and round-robin arbitration.
- Keeps its own occupancy count, so it rejects push-when-full and pop-when-empty without strobing the stack.
- Sits between the requester logic and the stack; it is the only master of the stack's control pins.

Parameters:
- DATA_WIDTH, 16, width of stack words; must equal the stack's data width.
- DEPTH, 3, stack capacity in words; must equal the stack's data count.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 request; held high until ack0.
- op0  input  1  requester 0 operation: 1 = push, 0 = pop.
- wdata0  input  DATA_WIDTH  requester 0 push data.
- req1, op1, wdata1  input  1/1/DATA_WIDTH  same for requester 1.
- ack0, ack1  output  1  one-cycle completion pulse per requester.
- err  output  1  valid with ack: 1 = operation rejected (full or empty).
- rdata  output  DATA_WIDTH  popped word; valid with ack on a successful pop.
- count  output  clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- busy  output  1  high whenever the FSM is not in IDLE.
- stk_push, stk_pop  output  1  stack strobes; never both high.
- stk_data_in  output  DATA_WIDTH  data to the stack.
- stk_data_out  input  DATA_WIDTH  stack output; valid the cycle after a strobe.
- reject_count  output  8  see Optional Feature.

Behaviour:
- All outputs are registered. Reset values: ack0 = ack1 = err = 0, rdata = 0, count = 0, stk_push = stk_pop = 0, stk_data_in = 0, reject_count = 0, FSM = IDLE, last_grant = 1 (so requester 0 wins the first tie).
- FSM states: IDLE, ISSUE, CAPTURE.
- IDLE:
  - Eligible requester i: req_i = 1 and ack_i is not high this cycle, so a held req in the ack cycle is ignored.
  - If both are eligible, the grant goes to the one that is not last_grant. On grant: latch id, op and wdata; update last_grant.
  - Rejected op (push with count == DEPTH, or pop with count == 0): next cycle ack_id = 1 and err = 1; no strobe; stay in IDLE; count unchanged.
  - Accepted op: next state ISSUE.
- ISSUE, one cycle:
  - Push: stk_push = 1, stk_data_in = latched wdata.
  - Pop: stk_pop = 1.
  - count is updated (+1 or -1) at the end of this cycle. Next state CAPTURE.
- CAPTURE, one cycle:
  - Strobes are low.
  - Pop: rdata <= stk_data_out at the end of this cycle.
  - Push: rdata holds its previous value.
  - Next cycle ack_id = 1, err = 0; state returns to IDLE.
- Latency, with req sampled at edge 0:
  - Accepted op: ack high in cycle 3.
  - Rejected op: ack high in cycle 1.
- Requester rule: drop req, or present a new op, in the cycle after ack is seen.
- Round-robin fairness: with both requests held continuously, grants alternate 0, 1, 0, 1.
- req or op changing while the requester is granted has no effect; latched values are used.
- A non-granted requester waits; it is never dropped.
- Reset asserted mid-operation:
  - FSM returns to IDLE, strobes are low from the next cycle, and the in-flight op gets no ack.
  - The stack instance must be reinitialised together with the arbiter, because count restarts at 0.

Optional Feature:
- Macro: STACK_ARB_STATS_EN.
- Defined: reject_count increments on every rejected op and saturates at 255; it clears on reset.
- Not defined: reject_count is tied to 0 and no counter logic is built. The port is present in both builds.

Test Plan:
- Requester 0 pushes 0x1111, 0x2222, 0x3333 -> each ack0 3 cycles after req, err = 0, count reaches 3; a 4th push of 0x4444 -> ack0 1 cycle after req, err = 1, no stk_push pulse, count stays 3.
- From full, requester 1 pops three times -> rdata 0x3333, 0x2222, 0x1111 in LIFO order, count reaches 0; a 4th pop -> err = 1, no stk_pop pulse.
- req0 and req1 both assert in the same cycle after reset -> requester 0 granted first, then requester 1; with both held, 4 ops alternate 0, 1, 0, 1.
- Requester 1 pops 0x00AA while requester 0 waits with a push of 0x0055 -> requester 0 is served right after ack1, with no lost request and count consistent.
- Reset pulsed during ISSUE of a push -> no ack, strobes low the next cycle, count = 0, busy = 0.
- With STACK_ARB_STATS_EN, 300 pops on an empty stack -> reject_count = 255; without the macro -> reject_count = 0.
